bus_line_memory: RTL
====================

Name: bus_line_memory

Overview:
- Single-port, line-granular main-memory responder: the target end of the 128-bit cache bus that the CPU top drives through its cache arbiter.
- Accepts one read or write line request at a time and acknowledges it after a fixed, parameterised latency with a one-cycle valid pulse.
- Serves as the simulation and FPGA backing store behind the I$/D$ arbiter.

Parameters:
- BUS_ADDRESS_WIDTH, 20, byte-address width of the bus.
- BUS_DATA_WIDTH_SHIFT, 4, log2 of bytes per line; line = 2**SHIFT*8 bits (128).
- DEPTH_LINES, 4096, number of lines implemented.
- LATENCY, 4, cycles from request-sample edge to ack; legal range 1..15.
- INIT_FILE, "", hex file for $readmemh at elaboration; empty means no init.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- bus_addr_i  in  BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT  line address, [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT]
- bus_data_i  in  BUS_DATA_WIDTH  write line data
- bus_we_i  in  1  1 = write, 0 = read
- bus_valid_i  in  1  request valid; master holds it and addr/we/data stable until ack
- bus_data_o  out  BUS_DATA_WIDTH  read line data
- bus_valid_o  out  1  one-cycle ack; read data valid in the same cycle

Behaviour:
- BUS_DATA_WIDTH = (2**BUS_DATA_WIDTH_SHIFT)*8.
- FSM states: IDLE, BUSY, ACK, DRAIN.

Reset (async, rst_i=1):
- State goes to IDLE; counter = 0; bus_valid_o = 0; bus_data_o = 0.
- Memory array is not cleared.
- A request in flight when reset asserts is discarded; its write is never performed.

IDLE:
- At a clock edge with bus_valid_i = 1, latch addr, we and data into request registers.
- Load counter with LATENCY-1 and go to BUSY.
- If LATENCY = 1, go directly to ACK instead.

BUSY:
- Decrement counter each edge.
- At the edge where counter = 0 (or directly when LATENCY = 1), enter ACK and perform the access on that same edge:
  - Read: bus_data_o <= mem[latched addr].
  - Write: mem[latched addr] <= latched data; bus_data_o keeps its prior value.

ACK:
- bus_valid_o = 1 for exactly this one cycle.
- Next edge: if bus_valid_i = 1, go to DRAIN; else go to IDLE.

DRAIN:
- bus_valid_o = 0; wait until bus_valid_i = 0, then go to IDLE.
- Guarantees a held request is never served twice.
- Back-to-back requests therefore need bus_valid_i to drop for at least one cycle.

Timing and data rules:
- Ack latency: request sampled at edge E; bus_valid_o is high during the cycle following edge E+LATENCY.
- Addresses are latched at sample time; input changes during BUSY are ignored.
- bus_data_o holds its last value outside ACK; consumers sample it only while bus_valid_o = 1.

Out-of-range address (line index >= DEPTH_LINES):
- Read returns all zeros.
- Write is dropped.
- Ack timing is unchanged.
- Index uses the full line-address width, with no silent wrap.

Storage and synthesis:
- Storage is a single reg array of DEPTH_LINES x BUS_DATA_WIDTH.
- Access is synchronous to clk_i so the array infers BRAM.
- Elaboration prints an error if LATENCY < 1 or LATENCY > 15.

Test Plan:
- Reset then idle: rst_i pulse, no requests for 10 cycles -> bus_valid_o stays 0, bus_data_o = 0.
- Write/read, LATENCY=4: write 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to line 0x010 sampled at edge E -> ack in the cycle after E+4. Then read line 0x010 -> ack after 4 cycles with identical data.
- LATENCY=1 with held valid: read line 0x005 held high for 6 cycles -> exactly one ack pulse, cycle after the sample edge; FSM waits in DRAIN until valid drops.
- Out of range, DEPTH_LINES=4096: write 128'hFF..FF to line 0x1000, then read 0x1000 -> read returns 0. Line 0x000 is unchanged.
- Input change mid-request: read line 0x020 issued, addr switched to 0x021 during BUSY -> returned data is mem[0x020].
- Reset mid-write: write to line 0x030 issued, rst_i asserted 2 cycles later (before ack) -> no ack; a subsequent read of 0x030 returns its pre-write contents.

Source files
------------

// File: rtl/bus_line_memory.sv
// bus_line_memory: line-granular main-memory responder on the 128-bit cache bus.
// Takes one read or write line request at a time. After a fixed LATENCY it
// acknowledges with a single-cycle bus_valid_o pulse. A request that the master
// keeps asserting after its ack is absorbed in DRAIN, so it is served only once.
`timescale 1ns/1ps

module bus_line_memory #(
   parameter int    BUS_ADDRESS_WIDTH    = 20,
   parameter int    BUS_DATA_WIDTH_SHIFT = 4,
   parameter int    DEPTH_LINES          = 4096,
   parameter int    LATENCY              = 4,
   parameter string INIT_FILE            = "",
   localparam int   BUS_DATA_WIDTH       = (2**BUS_DATA_WIDTH_SHIFT) * 8
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   input  logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] bus_addr_i,
   input  logic [BUS_DATA_WIDTH-1:0]                      bus_data_i,
   input  logic                                          bus_we_i,
   input  logic                                          bus_valid_i,
   output logic [BUS_DATA_WIDTH-1:0]                      bus_data_o,
   output logic                                          bus_valid_o
);

   localparam int IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;

   // FSM encoding
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] ACK   = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   // The counter is 4 bits wide because LATENCY is at most 15.
   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("bus_line_memory: LATENCY=%0d is outside the legal range 1..15", LATENCY);
   end

   logic [1:0]                                    state;
   logic [3:0]                                    count;
   logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] req_addr;
   logic [BUS_DATA_WIDTH-1:0]                     req_data;
   logic                                          req_we;

   logic [BUS_DATA_WIDTH-1:0] mem [DEPTH_LINES];

   // Access-side view of the current request. With LATENCY = 1 the access
   // happens on the same edge that samples the request, before the request
   // registers hold it. In that case the held bus inputs are used directly.
   logic                                          acc_fire;
   logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] acc_addr;
   logic [BUS_DATA_WIDTH-1:0]                     acc_data;
   logic                                          acc_we;
   logic [IDX_W-1:0]                              acc_idx;
   logic                                          acc_in_range;
   logic                                          mem_wr;

   // Select the request source and decide whether this edge performs the access.
   always_comb begin
      // NOTE: give every always_comb output a value on every path, or a latch is inferred.
      acc_fire = 1'b0;
      acc_addr = req_addr;
      acc_data = req_data;
      acc_we   = req_we;
      if (state == IDLE) begin
         acc_addr = bus_addr_i;
         acc_data = bus_data_i;
         acc_we   = bus_we_i;
         acc_fire = (LATENCY == 1) && bus_valid_i;
      end else if (state == BUSY) begin
         acc_fire = (count == 4'd0);
      end
   end

   // The full line address is compared against the depth. A line index past
   // the end therefore never wraps onto a real line.
   assign acc_idx      = IDX_W'(acc_addr);
   assign acc_in_range = (64'(acc_addr) < 64'(DEPTH_LINES));

   // While reset is held, no write commits. This covers the LATENCY = 1 path,
   // where IDLE alone could fire the access.
   assign mem_wr = acc_fire && acc_we && acc_in_range && !rst_i;

   // Request FSM, latency counter and read-data register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         count      <= 4'd0;
         req_addr   <= '0;
         req_data   <= '0;
         req_we     <= 1'b0;
         bus_data_o <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every register updates from pre-edge values.
         case (state)
            IDLE: begin
               if (bus_valid_i) begin
                  req_addr <= bus_addr_i;
                  req_data <= bus_data_i;
                  req_we   <= bus_we_i;
                  if (LATENCY == 1) begin
                     state <= ACK;
                  end else begin
                     count <= 4'(LATENCY - 1);
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (count == 4'd0) begin
                  state <= ACK;
               end else begin
                  count <= count - 4'd1;
               end
            end
            ACK: begin
               state <= bus_valid_i ? DRAIN : IDLE;
            end
            DRAIN: begin
               if (!bus_valid_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // A read updates the output register on the edge that enters ACK.
         // A write leaves the output holding its previous value.
         if (acc_fire && !acc_we) begin
            bus_data_o <= acc_in_range ? mem[acc_idx] : '0;
         end
      end
   end

   // Line store write port. It has no reset so the array maps onto block RAM.
   always_ff @(posedge clk_i) begin
      // NOTE: the memory array is never reset; its contents survive rst_i.
      if (mem_wr) begin
         mem[acc_idx] <= acc_data;
      end
   end

   assign bus_valid_o = (state == ACK);

endmodule
